// File: rtl/sd_stream_pkg.sv
// Shared types and sector geometry for the SD block streamer.
package sd_stream_pkg;

  localparam int unsigned BLOCK_BYTES = 512;
  localparam int unsigned BLOCK_AW    = 9;
  localparam int unsigned CNT_W       = BLOCK_AW + 1;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StFill,
    StDrain,
    StNext,
    StDone
  } state_e;

endpackage

// File: rtl/sd_block_buf.sv
// 512x8 single-port sector buffer with a registered (1-cycle) read.
module sd_block_buf
  import sd_stream_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                we,
  input  logic                re,
  input  logic [BLOCK_AW-1:0] addr,
  input  logic [7:0]          wdata,
  output logic [7:0]          rdata
);

  logic [7:0] mem [BLOCK_BYTES];
  logic [7:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Read register only updates on re, so it holds the presented byte under backpressure.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rdata_q <= 8'h00;
    end else if (re) begin
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sd_block_streamer.sv
// Walks consecutive SD blocks, buffers each sector and replays it as a valid/ready byte stream.
module sd_block_streamer
  import sd_stream_pkg::*;
#(
  parameter logic [31:0] START_BLOCK = 32'h2000,
  parameter int unsigned MAX_BLOCKS  = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        stop,
  input  logic        init_finished,
  output logic        rd_req,
  output logic [31:0] rd_addr,
  input  logic [7:0]  sd_dout,
  input  logic        sd_valid,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic [31:0] blk_count,
  output logic        busy,
  output logic        done,
  output logic        err
);

  state_e state_q, state_d;

  logic [31:0]      rd_addr_q, rd_addr_d;
  logic [31:0]      blk_count_q, blk_count_d;
  logic             err_q, err_d;
  logic             stop_pend_q, stop_pend_d;
  logic             drain_stop_q, drain_stop_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic             byte_valid_q, byte_valid_d;

  logic                start_ok;
  logic                in_fill;
  logic                in_drain;
  logic                fire;
  logic                rd_all_issued;
  logic                last_fire;
  logic                abort;
  logic                finish;
  logic                ram_we;
  logic                ram_re;
  logic [BLOCK_AW-1:0] ram_addr;
  logic [7:0]          ram_rdata;

  assign start_ok      = start && init_finished;
  assign in_fill       = (state_q == StFill);
  assign in_drain      = (state_q == StDrain);
  assign fire          = byte_valid_q && byte_ready;
  assign rd_all_issued = (rd_cnt_q == CNT_W'(BLOCK_BYTES));
  assign last_fire     = in_drain && fire && rd_all_issued;
  // Only a stop raised during DRAIN aborts it; a stop seen in FILL lets the sector stream out.
  assign abort         = in_drain && !last_fire && (drain_stop_q || stop)
                         && (fire || !byte_valid_q);
  assign finish        = (blk_count_q == 32'(MAX_BLOCKS)) || stop_pend_q || stop;
  // Prefetch the next address whenever the output slot is empty or being consumed.
  assign ram_re        = in_drain && !rd_all_issued && !abort && (!byte_valid_q || byte_ready);
  assign ram_we        = in_fill && sd_valid;
  assign ram_addr      = in_fill ? wr_cnt_q[BLOCK_AW-1:0] : rd_cnt_q[BLOCK_AW-1:0];

  sd_block_buf u_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (ram_we),
    .re      (ram_re),
    .addr    (ram_addr),
    .wdata   (sd_dout),
    .rdata   (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: if (start_ok) state_d = StReq;
      StReq:          state_d = StFill;
      StFill:         if (sd_valid && wr_cnt_q == CNT_W'(BLOCK_BYTES - 1)) state_d = StDrain;
      StDrain: begin
        if (last_fire) begin
          state_d = StNext;
        end else if (abort) begin
          state_d = StDone;
        end
      end
      StNext:         state_d = finish ? StDone : StReq;
      default:        state_d = StIdle;
    endcase
  end

  always_comb begin
    rd_addr_d    = rd_addr_q;
    blk_count_d  = blk_count_q;
    err_d        = err_q;
    stop_pend_d  = stop_pend_q;
    drain_stop_d = drain_stop_q;
    wr_cnt_d     = wr_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    byte_valid_d = byte_valid_q;

    if ((state_q == StIdle || state_q == StDone) && start_ok) begin
      rd_addr_d    = START_BLOCK;
      blk_count_d  = 32'd0;
      err_d        = 1'b0;
      stop_pend_d  = 1'b0;
      drain_stop_d = 1'b0;
    end

    if (busy && stop) stop_pend_d = 1'b1;
    if (in_drain && stop) drain_stop_d = 1'b1;

    if (state_q == StReq) begin
      wr_cnt_d     = '0;
      rd_cnt_d     = '0;
      byte_valid_d = 1'b0;
    end

    if (ram_we) wr_cnt_d = wr_cnt_q + 1'b1;

    if (in_drain) begin
      if (ram_re) begin
        rd_cnt_d     = rd_cnt_q + 1'b1;
        byte_valid_d = 1'b1;
      end else if (fire || abort) begin
        byte_valid_d = 1'b0;
      end
      if (last_fire) blk_count_d = blk_count_q + 32'd1;
    end

    if (state_q == StNext && !finish) rd_addr_d = rd_addr_q + 32'd1;

    // Stray controller data is dropped; it only flags the error.
    if (sd_valid && !in_fill) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_addr_q    <= START_BLOCK;
      blk_count_q  <= 32'd0;
      err_q        <= 1'b0;
      stop_pend_q  <= 1'b0;
      drain_stop_q <= 1'b0;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      byte_valid_q <= 1'b0;
    end else begin
      rd_addr_q    <= rd_addr_d;
      blk_count_q  <= blk_count_d;
      err_q        <= err_d;
      stop_pend_q  <= stop_pend_d;
      drain_stop_q <= drain_stop_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      byte_valid_q <= byte_valid_d;
    end
  end

  always_comb begin
    rd_req     = (state_q == StReq);
    busy       = (state_q != StIdle) && (state_q != StDone);
    done       = (state_q == StDone);
    rd_addr    = rd_addr_q;
    blk_count  = blk_count_q;
    err        = err_q;
    byte_valid = byte_valid_q;
    byte_out   = ram_rdata;
  end

endmodule

// File: tb/tb_sd_block_streamer.sv
// Directed bench: SD controller model driving sectors, consumer with selectable backpressure.
module tb_sd_block_streamer;

  localparam logic [31:0] START = 32'h2000;

  logic        clk = 1'b0;
  logic        reset_n, start, stop, init_finished;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic [7:0]  sd_dout;
  logic        sd_valid;
  logic [7:0]  byte_out;
  logic        byte_valid, byte_ready;
  logic [31:0] blk_count;
  logic        busy, done, err;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          last_hs = 0;
  int          stab_bad = 0;
  int          ready_mode = 0;
  bit          hold_pending = 1'b0;
  logic [7:0]  held;
  logic [7:0]  rx[$];
  logic [31:0] req_addr[$];
  int          gaps[$];

  always #5 clk = ~clk;

  sd_block_streamer #(
    .START_BLOCK (START),
    .MAX_BLOCKS  (3)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .stop          (stop),
    .init_finished (init_finished),
    .rd_req        (rd_req),
    .rd_addr       (rd_addr),
    .sd_dout       (sd_dout),
    .sd_valid      (sd_valid),
    .byte_out      (byte_out),
    .byte_valid    (byte_valid),
    .byte_ready    (byte_ready),
    .blk_count     (blk_count),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  // Observe handshakes, read requests and backpressure stability mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (reset_n) begin
      if (hold_pending && !(byte_valid && byte_out == held)) stab_bad++;
      hold_pending = byte_valid && !byte_ready;
      held = byte_out;
      if (byte_valid && byte_ready) begin
        rx.push_back(byte_out);
        last_hs = cyc;
      end
      if (rd_req) begin
        req_addr.push_back(rd_addr);
        if (rx.size() > 0) gaps.push_back(cyc - last_hs);
      end
    end else begin
      hold_pending = 1'b0;
    end
  end

  initial begin
    byte_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       byte_ready = 1'b1;
        1:       byte_ready = ($urandom_range(0, 9) < 3);
        default: byte_ready = 1'b0;
      endcase
    end
  end

  function automatic logic [7:0] exp_byte(input int blk, input int k);
    return 8'(k + 3 * blk);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    rx.delete();
    req_addr.delete();
    gaps.delete();
    stab_bad = 0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_rd_req", {31'd0, rd_req}, 32'd1);
    check("start_busy", {31'd0, busy}, 32'd1);
    check("start_err_clr", {31'd0, err}, 32'd0);
  endtask

  task automatic wait_req();
    int n = 0;
    while (!rd_req && n < 4000) begin
      step();
      n++;
    end
    check("rd_req_seen", {31'd0, rd_req}, 32'd1);
  endtask

  task automatic fill_block(input int blk, input int stop_at);
    wait_req();
    step();
    for (int k = 0; k < 512; k++) begin
      if (k % 97 == 50) begin
        sd_valid = 1'b0;
        stop = 1'b0;
        step();
      end
      sd_valid = 1'b1;
      sd_dout  = exp_byte(blk, k);
      stop     = (k == stop_at);
      step();
    end
    sd_valid = 1'b0;
    stop     = 1'b0;
    check("drain_lat_t1", {31'd0, byte_valid}, 32'd0);
    step();
    check("drain_lat_t2", {31'd0, byte_valid}, 32'd1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 8000) begin
      step();
      n++;
    end
    check("done", {31'd0, done}, 32'd1);
    check("busy_low", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_rx(input string tag, input int nblk);
    int bad = 0;
    check({tag, "_len"}, rx.size(), nblk * 512);
    for (int i = 0; i < rx.size(); i++) begin
      if (rx[i] !== exp_byte(i / 512, i % 512)) bad++;
    end
    check({tag, "_data"}, bad, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rd_req"}, {31'd0, rd_req}, 32'd0);
    check({tag, "_rd_addr"}, rd_addr, START);
    check({tag, "_byte_out"}, {24'd0, byte_out}, 32'd0);
    check({tag, "_byte_valid"}, {31'd0, byte_valid}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_err"}, {31'd0, err}, 32'd0);
    check({tag, "_blk_count"}, blk_count, 32'd0);
  endtask

  task automatic run_three(input string tag);
    clear_log();
    do_start();
    for (int b = 0; b < 3; b++) fill_block(b, -1);
    wait_done();
    check_rx(tag, 3);
    check({tag, "_blk_count"}, blk_count, 32'd3);
    check({tag, "_nreq"}, req_addr.size(), 32'd3);
    for (int i = 0; i < req_addr.size(); i++) begin
      check({tag, "_req_addr"}, req_addr[i], START + 32'(i));
    end
  endtask

  initial begin
    reset_n       = 1'b0;
    start         = 1'b0;
    stop          = 1'b0;
    init_finished = 1'b1;
    sd_valid      = 1'b0;
    sd_dout       = 8'h00;
    repeat (3) step();
    check_reset_vals("reset");
    reset_n = 1'b1;
    step();

    // Stray controller data while idle, then a start that must be ignored without init.
    sd_valid = 1'b1;
    sd_dout  = 8'hA5;
    step();
    sd_valid = 1'b0;
    check("idle_err_set", {31'd0, err}, 32'd1);
    init_finished = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_no_init", {31'd0, busy}, 32'd0);
    check("err_kept", {31'd0, err}, 32'd1);
    init_finished = 1'b1;
    step();

    // Multi-block, consumer always ready.
    ready_mode = 0;
    run_three("multi");
    check("multi_err", {31'd0, err}, 32'd0);
    check("multi_ngaps", gaps.size(), 32'd2);
    for (int i = 0; i < gaps.size(); i++) check("multi_gap", gaps[i], 32'd2);

    // Same stream under ~30% ready duty.
    ready_mode = 1;
    run_three("bp");
    check("bp_stable", stab_bad, 32'd0);
    ready_mode = 0;

    // Stop during FILL of block 0: full sector, then DONE.
    clear_log();
    do_start();
    fill_block(0, 200);
    wait_done();
    check_rx("stopfill", 1);
    check("stopfill_blk_count", blk_count, 32'd1);
    check("stopfill_nreq", req_addr.size(), 32'd1);

    // Stop after 100 drained bytes: abort without counting the block.
    clear_log();
    do_start();
    fill_block(0, -1);
    begin
      int n = 0;
      while (rx.size() < 100 && n < 2000) begin
        step();
        n++;
      end
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    wait_done();
    check("stopdrain_len_ok", {31'd0, (rx.size() >= 100 && rx.size() <= 101)}, 32'd1);
    check("stopdrain_blk_count", blk_count, 32'd0);
    check("stopdrain_valid", {31'd0, byte_valid}, 32'd0);

    // Reset in the middle of FILL, then a fresh stream.
    clear_log();
    do_start();
    wait_req();
    step();
    for (int k = 0; k < 100; k++) begin
      sd_valid = 1'b1;
      sd_dout  = 8'hFF;
      step();
    end
    sd_valid = 1'b0;
    reset_n  = 1'b0;
    step();
    check_reset_vals("midreset");
    reset_n = 1'b1;
    step();
    run_three("restart");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sd_block_streamer.md
# sd_block_streamer

Converts bursty per-sector SD card reads into a flow-controlled byte stream. Sits between the SPI `sd_card` controller and any byte consumer, such as a text scanner, tag matcher or word counter. It walks consecutive block addresses from a start block, issues one read request per block, and buffers each 512-byte sector in a local RAM. It then presents the bytes in order on a valid/ready interface, so consumers never have to handle `sd_valid` timing or sector boundaries themselves.

## Interface
- `START_BLOCK`, default 32'h2000: first block address read after `start`.
- `MAX_BLOCKS`, default 1024: number of blocks streamed before stopping automatically (≥1).
- `clk` in, 1 bit: system clock. The `sd_card` controller runs on this clock once `init_finished` is high.
- `reset_n` in, 1 bit: reset, synchronous, active-low; clock `clk`.
- `start` in, 1 bit: one-cycle pulse that begins streaming from `START_BLOCK`.
- `stop` in, 1 bit: level or pulse requesting an early end of the stream.
- `init_finished` in, 1 bit: SD controller ready.
- `rd_req` out, 1 bit: one-cycle read request to the SD controller.
- `rd_addr` out, 32 bits: block address for `rd_req`, held stable at all times.
- `sd_dout` in, 8 bits: sector byte from the controller.
- `sd_valid` in, 1 bit: `sd_dout` is valid this cycle.
- `byte_out` out, 8 bits: stream data.
- `byte_valid` out, 1 bit: `byte_out` is valid.
- `byte_ready` in, 1 bit: consumer accepts the byte.
- `blk_count` out, 32 bits: number of blocks fully drained since `start`.
- `busy` out, 1 bit: high in any state except IDLE and DONE.
- `done` out, 1 bit: level signal, high in DONE.
- `err` out, 1 bit: sticky flag, `sd_valid` seen outside FILL. Cleared by reset or `start`.

## Operation
- **States:** IDLE, REQ, FILL, DRAIN, NEXT, DONE.
- **IDLE:** on `start && init_finished`:
  - `rd_addr` ← `START_BLOCK`, `blk_count` ← 0, `err` ← 0.
  - Go to REQ.
  - `start` without `init_finished` is ignored.
- **REQ:** `rd_req` = 1 for exactly one cycle, `wr_cnt` ← 0, go to FILL.
- **FILL:**
  - Each `sd_valid` writes `sd_dout` to `buf[wr_cnt]` and increments `wr_cnt` (10-bit).
  - The cycle that writes byte 511 moves the FSM to DRAIN.
- **DRAIN:**
  - Bytes `buf[0..511]` are presented in order.
  - A byte is transferred on `byte_valid && byte_ready`.
  - `byte_out` and `byte_valid` are stable while `byte_ready` is low.
  - Once byte 511 is transferred: `blk_count` += 1, go to NEXT.
- **NEXT:**
  - If `blk_count == MAX_BLOCKS` or `stop_pend` is set: go to DONE.
  - Otherwise `rd_addr` += 1 (32-bit, wraps at 2^32−1 → 0) and go to REQ.
- **DONE:** `start` (with `init_finished`) restarts exactly as from IDLE.
- **stop handling:**
  - `stop` sets `stop_pend` in any busy state.
  - In FILL, the sector read always completes, because the controller cannot be aborted. The FSM then enters DRAIN normally and the whole sector is streamed.
  - In DRAIN, `stop_pend` causes a jump to DONE right after the next handshake, or immediately if `byte_valid` is not yet high. The remaining buffered bytes are discarded and `blk_count` is not incremented.
  - `stop_pend` is cleared on `start`.
- **`sd_valid` outside FILL:** the data is dropped and `err` ← 1.
- **Simultaneous `start` and `stop` in IDLE or DONE:** `start` wins and `stop` is ignored.
- **Reset mid-operation:** everything returns to reset values within one cycle. The SD controller shares this reset, so no read is left in flight.

## Timing
- **Reset values:**
  - `rd_req` = 0, `rd_addr` = `START_BLOCK`, `byte_out` = 0.
  - `byte_valid`, `busy`, `done`, `err` = 0.
  - `blk_count` = 0, state = IDLE.
- **Start latency:** `start` at cycle t gives `rd_req` at t+1.
- **Fill to drain latency:** the last `sd_valid` at t puts the FSM in DRAIN at t+1 and raises `byte_valid` at t+2 (one cycle of synchronous RAM read).
- **Drain throughput:** with `byte_ready` held high, one byte per cycle with no bubbles. This requires a prefetch of the next RAM address on every handshake. 512 consecutive cycles cover the sector.
- **Block to block:** from the last handshake of block N to `rd_req` for block N+1 is 2 cycles (NEXT, then REQ).
- **`byte_valid`** never drops without a handshake, except on the `stop` abort or reset.

## Structure
- **Package `sd_stream_pkg`:** state enumeration, `BLOCK_BYTES` = 512, `BLOCK_AW` = 9.
- **Sub-module `sd_block_buf`:** 512×8 single-port RAM with synchronous 1-cycle read, inferred as BRAM. Write port driven in FILL, read port in DRAIN.
- **Top:** FSM, `wr_cnt`/`rd_cnt` counters, output prefetch register, address/count registers.

## Test plan
- **Single block:** `MAX_BLOCKS`=1, controller model sends bytes `k & 8'hFF` for k=0..511, `byte_ready`=1 → bytes 0x00..0xFF twice in order, `blk_count`=1, `done`=1, exactly one `rd_req` with `rd_addr`=0x2000.
- **Multi-block:** `MAX_BLOCKS`=3 → `rd_req` seen with addresses 0x2000, 0x2001, 0x2002; 1536 bytes delivered; `rd_req` follows each last handshake by 2 cycles.
- **Backpressure:** random `byte_ready` at about 30% duty → stream unchanged, `byte_out` stable whenever `byte_valid && !byte_ready`.
- **Stop:** `stop` pulsed mid-FILL of block 0 → full 512 bytes delivered, then DONE with `blk_count`=1. `stop` pulsed after 100 bytes of DRAIN → DONE with ≤101 bytes delivered and `blk_count`=0.
- **Error and reset:** `sd_valid` injected in IDLE → `err`=1, stream unaffected. `reset_n`=0 mid-FILL → all outputs at reset values next cycle, and a fresh `start` works.
